// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the 1280x720@60 display path.
// The sprite renderers and the output mixer import the same constants so that
// every block agrees on the coordinate width and the line/frame geometry.
package video_timing_pkg;

   // Width of the pixel coordinates and of the frame counter.
   localparam int COORD_W = 16;

   // Horizontal timing, in pixels: active, front porch, sync, back porch.
   localparam int H_ACTIVE = 1280;
   localparam int H_FP     = 110;
   localparam int H_SYNC   = 40;
   localparam int H_BP     = 220;

   // Vertical timing, in lines: active, front porch, sync, back porch.
   localparam int V_ACTIVE = 720;
   localparam int V_FP     = 5;
   localparam int V_SYNC   = 5;
   localparam int V_BP     = 20;

   // Full line length (1650) and full frame height (750).
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // True when lo <= pos < lo+len.
   function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                      input int lo, input int len);
      int p;
      p = int'(pos);
      return (p >= lo) && (p < (lo + len));
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: a wrap counter 0..TOTAL-1 with a count enable.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - advance by one position on this edge
//   cnt         - current position (registered); resets to TOTAL-1 so the
//                 first enabled edge lands on 0
//   wrap        - this edge moves the counter from TOTAL-1 back to 0
//   active_nxt  - the position being entered is inside the active window
//   sync_nxt    - the position being entered is inside the sync window
// The window decodes look at the next value, so a register fed from them
// lines up with cnt after the same edge.
module timing_axis_counter
   import video_timing_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL,
   parameter int ACTIVE     = H_ACTIVE,
   parameter int SYNC_START = H_ACTIVE + H_FP,
   parameter int SYNC_LEN   = H_SYNC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   output logic [COORD_W-1:0] cnt,
   output logic               wrap,
   output logic               active_nxt,
   output logic               sync_nxt
);

   localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

   logic [COORD_W-1:0] cnt_r;
   logic [COORD_W-1:0] nxt_s;
   logic               wrap_s;

   // Next position: hold, step, or wrap at the terminal count.
   always_comb begin
      nxt_s  = cnt_r;
      wrap_s = 1'b0;
      if (en) begin
         if (cnt_r == LAST) begin
            nxt_s  = COORD_W'(0);
            wrap_s = 1'b1;
         end else begin
            nxt_s  = cnt_r + COORD_W'(1);
         end
      end else begin
         nxt_s = cnt_r;
      end
   end

   // Position register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= LAST;
      end else begin
         cnt_r <= nxt_s;
      end
   end

   assign cnt        = cnt_r;
   assign wrap       = wrap_s;
   assign active_nxt = in_window(nxt_s, 0, ACTIVE);
   assign sync_nxt   = in_window(nxt_s, SYNC_START, SYNC_LEN);

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-rate raster timing generator (default 1280x720@60).
// Ports:
//   i_clk, i_rst_n  - pixel clock, asynchronous active-low reset
//   i_ce            - pixel advance enable
//   o_x, o_y        - current raster position
//   o_de            - position is inside the visible area
//   o_h_sync        - horizontal sync, active level H_SYNC_POL
//   o_v_sync        - vertical sync, active level V_SYNC_POL (whole lines)
//   o_line_start    - one-clock strobe on entering x=0
//   o_frame_start   - one-clock strobe on entering (0,0)
//   o_frame_cnt     - completed frames, wraps modulo 2^16
// All outputs are flops loaded from next-state decodes, so they always
// describe the same (o_x,o_y).
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE   = video_timing_pkg::H_ACTIVE,
   parameter int H_FP       = video_timing_pkg::H_FP,
   parameter int H_SYNC     = video_timing_pkg::H_SYNC,
   parameter int H_BP       = video_timing_pkg::H_BP,
   parameter int V_ACTIVE   = video_timing_pkg::V_ACTIVE,
   parameter int V_FP       = video_timing_pkg::V_FP,
   parameter int V_SYNC     = video_timing_pkg::V_SYNC,
   parameter int V_BP       = video_timing_pkg::V_BP,
   parameter bit H_SYNC_POL = 1'b1,
   parameter bit V_SYNC_POL = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ce,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic               o_de,
   output logic               o_h_sync,
   output logic               o_v_sync,
   output logic               o_line_start,
   output logic               o_frame_start,
   output logic [COORD_W-1:0] o_frame_cnt
);

   localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if ((H_LEN > 65535) || (V_LEN > 65535)) begin : g_bad_total
      $error("video_timing_gen: line or frame total exceeds 65535");
   end
   if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
       (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_zero
      $error("video_timing_gen: porch and sync widths must be non-zero");
   end

   logic h_wrap_s, h_active_s, h_sync_s;
   logic v_wrap_s, v_active_s, v_sync_s;

   logic               de_r;
   logic               h_sync_r;
   logic               v_sync_r;
   logic               line_start_r;
   logic               frame_start_r;
   logic [COORD_W-1:0] frame_cnt_r;
   logic               started_r;

   timing_axis_counter #(
      .TOTAL      (H_LEN),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_LEN   (H_SYNC)
   ) u_h_axis (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .en         (i_ce),
      .cnt        (o_x),
      .wrap       (h_wrap_s),
      .active_nxt (h_active_s),
      .sync_nxt   (h_sync_s)
   );

   // The vertical axis steps only on the edge that ends a line.
   timing_axis_counter #(
      .TOTAL      (V_LEN),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_LEN   (V_SYNC)
   ) u_v_axis (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .en         (h_wrap_s),
      .cnt        (o_y),
      .wrap       (v_wrap_s),
      .active_nxt (v_active_s),
      .sync_nxt   (v_sync_s)
   );

   // Output flops. The reset position is the last pixel of the last line,
   // so the first enabled edge is an ordinary wrap into (0,0); started_r
   // keeps that first entry from being counted as a completed frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         de_r          <= 1'b0;
         h_sync_r      <= ~H_SYNC_POL;
         v_sync_r      <= ~V_SYNC_POL;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_cnt_r   <= COORD_W'(0);
         started_r     <= 1'b0;
      end else begin
         de_r          <= h_active_s & v_active_s;
         h_sync_r      <= h_sync_s ? H_SYNC_POL : ~H_SYNC_POL;
         v_sync_r      <= v_sync_s ? V_SYNC_POL : ~V_SYNC_POL;
         line_start_r  <= h_wrap_s;
         frame_start_r <= h_wrap_s & v_wrap_s;
         started_r     <= started_r | i_ce;
         if (h_wrap_s & v_wrap_s & started_r) begin
            frame_cnt_r <= frame_cnt_r + COORD_W'(1);
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   assign o_de          = de_r;
   assign o_h_sync      = h_sync_r;
   assign o_v_sync      = v_sync_r;
   assign o_line_start  = line_start_r;
   assign o_frame_start = frame_start_r;
   assign o_frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. One instance uses the 720p defaults (reset
// values, one full line); a second uses a tiny raster with active-low syncs
// (15 pixels x 8 lines) for whole frames, enable gating, async reset and the
// frame counter wrap.
//   small raster: x 0..7 active, 8..9 fp, 10..12 sync, 13..14 bp
//                 y 0..3 active, 4 fp,    5..6 sync,   7 bp
module tb_video_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_hd_n, ce_hd, rst_sm_n, ce_sm;
   logic [15:0] hd_x, hd_y, hd_fc, sm_x, sm_y, sm_fc;
   logic        hd_de, hd_hs, hd_vs, hd_ls, hd_fs;
   logic        sm_de, sm_hs, sm_vs, sm_ls, sm_fs;

   int n_checks = 0;
   int n_fail   = 0;

   video_timing_gen dut_hd (
      .i_clk (clk), .i_rst_n (rst_hd_n), .i_ce (ce_hd),
      .o_x (hd_x), .o_y (hd_y), .o_de (hd_de),
      .o_h_sync (hd_hs), .o_v_sync (hd_vs),
      .o_line_start (hd_ls), .o_frame_start (hd_fs), .o_frame_cnt (hd_fc)
   );

   video_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0)
   ) dut_sm (
      .i_clk (clk), .i_rst_n (rst_sm_n), .i_ce (ce_sm),
      .o_x (sm_x), .o_y (sm_y), .o_de (sm_de),
      .o_h_sync (sm_hs), .o_v_sync (sm_vs),
      .o_line_start (sm_ls), .o_frame_start (sm_fs), .o_frame_cnt (sm_fc)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One active edge, then sample on the falling edge.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int de_cnt, hs_cnt, hs_first, hs_last, ls_cnt, vs_cnt, xy_err;
      int e_xy, e_de, e_hs, e_vs, e_ls, e_fs, e_fc;
      int ex, ey, step_err, ls_hits, ls_wide, ls_c0, ls_c1;
      logic ls_prev;

      rst_hd_n = 1'b0; rst_sm_n = 1'b0;
      ce_hd    = 1'b1; ce_sm    = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state, with ce high and clocks running (no strobes allowed).
      check_val("hd_rst_x",  hd_x,  1649);
      check_val("hd_rst_y",  hd_y,  749);
      check_val("hd_rst_de", hd_de, 0);
      check_val("hd_rst_hs", hd_hs, 0);
      check_val("hd_rst_vs", hd_vs, 0);
      check_val("hd_rst_ls", hd_ls, 0);
      check_val("hd_rst_fs", hd_fs, 0);
      check_val("hd_rst_fc", hd_fc, 0);
      check_val("sm_rst_x",  sm_x,  14);
      check_val("sm_rst_y",  sm_y,  7);
      check_val("sm_rst_hs", sm_hs, 1);
      check_val("sm_rst_vs", sm_vs, 1);

      // First enabled edge enters (0,0).
      rst_hd_n = 1'b1;
      tick;
      check_val("hd_first_x",  hd_x,  0);
      check_val("hd_first_y",  hd_y,  0);
      check_val("hd_first_de", hd_de, 1);
      check_val("hd_first_fs", hd_fs, 1);
      check_val("hd_first_ls", hd_ls, 1);
      check_val("hd_first_fc", hd_fc, 0);

      // One full 720p line.
      de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
      ls_cnt = 0; vs_cnt = 0; xy_err = 0;
      for (int i = 0; i < 1650; i++) begin
         if (hd_x != 16'(i) || hd_y != 16'd0) xy_err++;
         if (hd_de) de_cnt++;
         if (hd_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (hd_ls) ls_cnt++;
         if (hd_vs) vs_cnt++;
         tick;
      end
      check_val("hd_line_xy",    xy_err,   0);
      check_val("hd_de_len",     de_cnt,   1280);
      check_val("hd_hs_len",     hs_cnt,   40);
      check_val("hd_hs_first",   hs_first, 1390);
      check_val("hd_hs_last",    hs_last,  1429);
      check_val("hd_ls_in_line", ls_cnt,   1);
      check_val("hd_vs_line0",   vs_cnt,   0);
      check_val("hd_l1_x",       hd_x,     0);
      check_val("hd_l1_y",       hd_y,     1);
      check_val("hd_l1_ls",      hd_ls,    1);
      check_val("hd_l1_fs",      hd_fs,    0);

      // Asynchronous reset between edges: no clock needed.
      #2 rst_hd_n = 1'b0;
      #1;
      check_val("hd_arst_x",  hd_x,  1649);
      check_val("hd_arst_y",  hd_y,  749);
      check_val("hd_arst_de", hd_de, 0);
      check_val("hd_arst_ls", hd_ls, 0);
      ce_hd = 1'b0;

      // Small raster: two full frames against hand-derived windows.
      @(negedge clk);
      rst_sm_n = 1'b1;
      tick;
      e_xy = 0; e_de = 0; e_hs = 0; e_vs = 0; e_ls = 0; e_fs = 0; e_fc = 0;
      for (int f = 0; f < 2; f++) begin
         for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 15; x++) begin
               if (sm_x != 16'(x) || sm_y != 16'(y)) e_xy++;
               if (sm_de != ((x < 8) && (y < 4))) e_de++;
               if (sm_hs != !((x >= 10) && (x <= 12))) e_hs++;
               if (sm_vs != !((y >= 5) && (y <= 6))) e_vs++;
               if (sm_ls != (x == 0)) e_ls++;
               if (sm_fs != ((x == 0) && (y == 0))) e_fs++;
               if (sm_fc != 16'(f)) e_fc++;
               tick;
            end
         end
      end
      check_val("sm_frame_xy", e_xy, 0);
      check_val("sm_frame_de", e_de, 0);
      check_val("sm_frame_hs", e_hs, 0);
      check_val("sm_frame_vs", e_vs, 0);
      check_val("sm_frame_ls", e_ls, 0);
      check_val("sm_frame_fs", e_fs, 0);
      check_val("sm_frame_fc", e_fc, 0);
      check_val("sm_f2_x",  sm_x,  0);
      check_val("sm_f2_y",  sm_y,  0);
      check_val("sm_f2_fs", sm_fs, 1);
      check_val("sm_f2_fc", sm_fc, 2);

      // Enable in a 1-of-3 pattern: 30 advances over 90 clocks.
      ex = 0; ey = 0; step_err = 0; ls_hits = 0; ls_wide = 0;
      ls_c0 = -1; ls_c1 = -1; ls_prev = sm_ls;
      for (int c = 0; c < 90; c++) begin
         ce_sm = ((c % 3) == 0);
         tick;
         if (ce_sm) begin
            ex = (ex == 14) ? 0 : ex + 1;
            if (ex == 0) ey = (ey == 7) ? 0 : ey + 1;
         end
         if (sm_x != 16'(ex) || sm_y != 16'(ey)) step_err++;
         if (sm_ls) begin
            ls_hits++;
            if (ls_prev) ls_wide++;
            if (ls_c0 < 0) ls_c0 = c;
            else ls_c1 = c;
         end
         ls_prev = sm_ls;
      end
      ce_sm = 1'b1;
      check_val("ce3_steps",   step_err, 0);
      check_val("ce3_ls_hits", ls_hits,  2);
      check_val("ce3_ls_wide", ls_wide,  0);
      check_val("ce3_ls_c0",   ls_c0,    42);
      check_val("ce3_ls_per",  ls_c1 - ls_c0, 45);
      check_val("ce3_end_x",   sm_x,     0);
      check_val("ce3_end_y",   sm_y,     2);

      // Mid-frame asynchronous reset, then held across an enabled edge.
      repeat (5) tick;
      check_val("sm_mid_x",  sm_x,  5);
      check_val("sm_mid_de", sm_de, 1);
      #2 rst_sm_n = 1'b0;
      #1;
      check_val("sm_arst_x",  sm_x,  14);
      check_val("sm_arst_y",  sm_y,  7);
      check_val("sm_arst_de", sm_de, 0);
      check_val("sm_arst_hs", sm_hs, 1);
      check_val("sm_arst_vs", sm_vs, 1);
      check_val("sm_arst_fc", sm_fc, 0);
      @(negedge clk);
      tick;
      check_val("sm_hold_fs", sm_fs, 0);
      check_val("sm_hold_ls", sm_ls, 0);
      rst_sm_n = 1'b1;
      tick;
      check_val("sm_re_fs", sm_fs, 1);
      check_val("sm_re_ls", sm_ls, 1);
      check_val("sm_re_fc", sm_fc, 0);

      // Frame counter wrap 65535 -> 0 on the frame boundary.
      force dut_sm.frame_cnt_r = 16'hFFFF;
      #1;
      release dut_sm.frame_cnt_r;
      check_val("wrap_preset", sm_fc, 65535);
      repeat (119) tick;
      check_val("wrap_pre_x",  sm_x,  14);
      check_val("wrap_pre_y",  sm_y,  7);
      check_val("wrap_pre_fc", sm_fc, 65535);
      check_val("wrap_pre_fs", sm_fs, 0);
      tick;
      check_val("wrap_fc", sm_fc, 0);
      check_val("wrap_fs", sm_fs, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
